frog_move_ctrl: RTL and testbench
=================================

Name: frog_move_ctrl

Overview:
- Sequences player input into the frog cell array.
- Turns synchronous key levels into rate-limited, arbitrated, single-cycle move pulses (move_l/r/u/d) that drive every cell's L/R/U/D inputs.
- Tracks game phase (idle, playing, dead, won) and blocks moves outside play.
- Sits between the input-sync stage and the frog cell grid.

Parameters:
COOLDOWN, 4, minimum clk cycles between issued move pulses (legal range 1..255)
CNT_W, 8, width of the move_count output
REPEAT_PERIOD, 8, cycles between auto-repeat moves while a key is held (used only with FROG_AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_l, key_r, key_u, key_d  in  1 each  synchronous key levels, 1 = pressed
restart  in  1  synchronous; returns to IDLE from any state
frog_hit  in  1  collision from playfield, level
frog_home  in  1  frog reached goal row, level
move_l, move_r, move_u, move_d  out  1 each  one-cycle move pulses to cell array
game_state  out  2  00 IDLE, 01 PLAY, 10 DEAD, 11 WON
move_count  out  CNT_W  moves issued since restart

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all move_* = 0; move_count = 0; pending slot empty; cooldown counter = 0; key history flops = 0.
- Edge detect: a key's edge is set when key_x = 1 and key_x_q = 0. key_x_q is registered every cycle in all states.
- Arbitration of same-cycle edges:
  - l&r together cancel each other; u&d together cancel each other.
  - Of the remaining edges, priority is U > D > L > R. One winner per cycle.
- All outputs are registered. A move pulse goes high on the clock edge where the key edge is sampled and lasts exactly one cycle. At most one move_* is high in any cycle.
- PLAY internally has two sub-phases, READY and COOL. game_state reports 01 in both.
- State transitions:
  - IDLE: any key edge -> READY. That edge issues no move.
  - READY: winner exists -> pulse it, move_count++, counter = COOLDOWN-1, go to COOL.
  - COOL:
    - counter > 0: decrement the counter. Any winner is stored in the 1-deep pending slot; a newer winner overwrites an older one.
    - counter == 0 (release edge): if a winner exists this cycle, issue it. Otherwise, if pending is valid, issue pending. Either issue clears pending, reloads the counter and stays in COOL. With neither, go to READY.
  - Minimum spacing between pulses is exactly COOLDOWN cycles.
  - READY/COOL: frog_hit -> DEAD; else frog_home -> WON. Both high: DEAD wins. The hit/home check has priority over issuing a move in the same cycle. Entering DEAD or WON clears pending; move_* = 0 that cycle.
  - DEAD/WON: hold; no moves; move_count frozen.
  - restart = 1 in any state -> IDLE next edge, move_count = 0, pending cleared. restart has highest priority after reset.
- move_count saturates at 2^CNT_W-1 and does not wrap.
- frog_hit and frog_home are ignored in IDLE, DEAD and WON.
- Reset asserted mid-pulse clears move_* immediately (asynchronous).

Optional Feature:
Macro FROG_AUTO_REPEAT_EN.
- Defined: in PLAY, while the last-issued key stays held and no new edge occurs, a repeat request for that key is raised every REPEAT_PERIOD cycles after its pulse. The repeat is treated as a winner subject to the cooldown. Releasing the key stops the repeat.
- Not defined: only fresh edges generate moves; holding a key produces exactly one move.

Test Plan:
- Reset (0) with key_u held -> state 00, all moves 0, count 0. Release reset, raise key_u at edge 3 -> state 01, no move pulse. Raise key_l at edge 6 -> move_l high one cycle after edge 6, count 1.
- COOLDOWN=4, PLAY, key_r edge at edge 10, key_u edge at edge 11, key_d edge at edge 12 -> move_r at 10; d overwrites u in pending; move_d at edge 14; next fresh edge accepted at edge 18 or later.
- Same-cycle edges: l+r -> no pulse, count unchanged. u+l -> move_u only. l+d -> move_d only.
- frog_hit and frog_home both high at the release edge with pending valid -> state 10, no pulse, pending cleared. Key edges for 10 cycles -> no pulses. restart -> state 00, count 0.
- CNT_W=2: issue 5 moves -> count reads 1, 2, 3, 3, 3.
- With FROG_AUTO_REPEAT_EN, REPEAT_PERIOD=8, COOLDOWN=4, key_l held 30 cycles from edge 20 -> move_l at 20, 28, 36, 44. Without the macro -> move_l at 20 only.

Source files
------------

// File: rtl/frog_move_ctrl_if.sv
// Player-input bus between the input-sync stage, frog_move_ctrl and the frog cell grid.
// The controller uses the slave modport; the key/playfield source uses master.
interface frog_move_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             key_l;
  logic             key_r;
  logic             key_u;
  logic             key_d;
  logic             restart;
  logic             frog_hit;
  logic             frog_home;
  logic             move_l;
  logic             move_r;
  logic             move_u;
  logic             move_d;
  logic [1:0]       game_state;
  logic [CNT_W-1:0] move_count;

  modport master (
    output key_l, key_r, key_u, key_d, restart, frog_hit, frog_home,
    input  move_l, move_r, move_u, move_d, game_state, move_count
  );

  modport slave (
    input  key_l, key_r, key_u, key_d, restart, frog_hit, frog_home,
    output move_l, move_r, move_u, move_d, game_state, move_count
  );
endinterface

// File: rtl/frog_move_ctrl.sv
// Frog move sequencer: edge-detects keys, arbitrates, rate-limits moves and tracks game phase.
// Optional hold-to-repeat enabled by defining FROG_AUTO_REPEAT_EN.
module frog_move_ctrl #(
  parameter int unsigned COOLDOWN      = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic            clk,
  input  logic            reset,
  frog_move_ctrl_if.slave bus
);

  localparam int unsigned     CD_W      = 8;
  localparam int unsigned     RP_W      = 8;
  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN - 1);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Direction code doubles as bit index into {u,d,l,r}
  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_U = 2'd3;

`ifdef FROG_AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_COOL,
    S_DEAD,
    S_WON
  } state_t;

  state_t           state;
  logic [3:0]       key_now;
  logic [3:0]       key_q;
  logic [3:0]       key_edge;
  logic [3:0]       move_q;
  logic [CD_W-1:0]  cd_cnt;
  logic [CNT_W-1:0] move_count_q;
  logic             pend_vld;
  logic [1:0]       pend_dir;

  logic             eu, ed, el, er;
  logic             win_vld;
  logic [1:0]       win_dir;
  logic             rpt_req;
  logic             req_vld;
  logic [1:0]       req_dir;
  logic             in_play;
  logic             can_issue;
  logic             iss_vld;
  logic [1:0]       iss_dir;

  logic [RP_W-1:0]  rpt_cnt;
  logic             rpt_act;
  logic [1:0]       last_dir;

  assign key_now  = {bus.key_u, bus.key_d, bus.key_l, bus.key_r};
  assign key_edge = key_now & ~key_q;

  // Opposing edges cancel; survivors resolve U > D > L > R
  assign eu = key_edge[3] & ~key_edge[2];
  assign ed = key_edge[2] & ~key_edge[3];
  assign el = key_edge[1] & ~key_edge[0];
  assign er = key_edge[0] & ~key_edge[1];

  always_comb begin
    win_vld = 1'b1;
    win_dir = DIR_U;
    if (eu)      win_dir = DIR_U;
    else if (ed) win_dir = DIR_D;
    else if (el) win_dir = DIR_L;
    else if (er) win_dir = DIR_R;
    else         win_vld = 1'b0;
  end

  // Repeat request: last issued key still held, no fresh edge, period elapsed
  assign rpt_req = AUTO_RPT && rpt_act && (rpt_cnt == '0) &&
                   key_now[last_dir] && (key_edge == 4'b0000);

  always_comb begin
    req_vld   = win_vld | rpt_req;
    req_dir   = win_vld ? win_dir : last_dir;
    in_play   = (state == S_READY) || (state == S_COOL);
    can_issue = (state == S_READY) || ((state == S_COOL) && (cd_cnt == '0));
    iss_vld   = can_issue && (req_vld || pend_vld);
    iss_dir   = req_vld ? req_dir : pend_dir;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      key_q        <= '0;
      move_q       <= '0;
      cd_cnt       <= '0;
      move_count_q <= '0;
      pend_vld     <= 1'b0;
      pend_dir     <= DIR_U;
    end else begin
      key_q  <= key_now;
      move_q <= '0;
      if (bus.restart) begin
        state        <= S_IDLE;
        move_count_q <= '0;
        pend_vld     <= 1'b0;
        cd_cnt       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (key_edge != 4'b0000) state <= S_READY;
          end
          S_READY, S_COOL: begin
            if (bus.frog_hit) begin
              state    <= S_DEAD;
              pend_vld <= 1'b0;
            end else if (bus.frog_home) begin
              state    <= S_WON;
              pend_vld <= 1'b0;
            end else if (iss_vld) begin
              move_q   <= 4'b0001 << iss_dir;
              if (move_count_q != CNT_MAX) move_count_q <= move_count_q + 1'b1;
              cd_cnt   <= CD_RELOAD;
              pend_vld <= 1'b0;
              state    <= S_COOL;
            end else if (can_issue) begin
              state <= S_READY;
            end else begin
              // Still cooling: newest request replaces any older pending one
              cd_cnt <= cd_cnt - 1'b1;
              if (req_vld) begin
                pend_vld <= 1'b1;
                pend_dir <= req_dir;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Hold-to-repeat tracker; pruned away when the feature is disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt  <= '0;
      rpt_act  <= 1'b0;
      last_dir <= DIR_U;
    end else if (!in_play || bus.restart || bus.frog_hit || bus.frog_home) begin
      rpt_act <= 1'b0;
    end else if (iss_vld) begin
      rpt_act  <= 1'b1;
      rpt_cnt  <= RP_RELOAD;
      last_dir <= iss_dir;
    end else begin
      if (rpt_cnt != '0)       rpt_cnt <= rpt_cnt - 1'b1;
      if (!key_now[last_dir])  rpt_act <= 1'b0;
    end
  end

  always_comb begin
    case (state)
      S_READY, S_COOL: bus.game_state = 2'b01;
      S_DEAD:          bus.game_state = 2'b10;
      S_WON:           bus.game_state = 2'b11;
      default:         bus.game_state = 2'b00;
    endcase
  end

  assign bus.move_u     = move_q[DIR_U];
  assign bus.move_d     = move_q[DIR_D];
  assign bus.move_l     = move_q[DIR_L];
  assign bus.move_r     = move_q[DIR_R];
  assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Self-checking bench for frog_move_ctrl: directed scenarios plus random keys vs a timing-based model.
// Two instances share stimulus; the second uses a 2-bit move counter to exercise saturation.
module tb_frog_move_ctrl;
  localparam int CD = 4;
  localparam int RP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic key_l, key_r, key_u, key_d, restart, frog_hit, frog_home;

  frog_move_ctrl_if #(.CNT_W(8)) bus ();
  frog_move_ctrl_if #(.CNT_W(2)) bus2 ();

  assign bus.key_l = key_l;  assign bus.key_r = key_r;
  assign bus.key_u = key_u;  assign bus.key_d = key_d;
  assign bus.restart = restart;  assign bus.frog_hit = frog_hit;  assign bus.frog_home = frog_home;
  assign bus2.key_l = key_l; assign bus2.key_r = key_r;
  assign bus2.key_u = key_u; assign bus2.key_d = key_d;
  assign bus2.restart = restart; assign bus2.frog_hit = frog_hit; assign bus2.frog_home = frog_home;

  frog_move_ctrl #(.COOLDOWN(CD), .CNT_W(8), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  frog_move_ctrl #(.COOLDOWN(CD), .CNT_W(2), .REPEAT_PERIOD(RP)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 play, 2 dead, 3 won; cooldown tracked as time since last issue
  int         m_ph, m_last, m_cyc, m_cnt, m_pd, m_rdir;
  bit         m_pv, m_ract;
  logic [3:0] m_kq, e_mv;

  task automatic model_reset();
    m_ph = 0; m_last = -1000; m_cyc = 0; m_cnt = 0; m_pd = 0; m_rdir = 0;
    m_pv = 1'b0; m_ract = 1'b0; m_kq = 4'b0000; e_mv = 4'b0000;
  endtask

  task automatic model_clock();
    logic [3:0] k, e;
    int rq, d;
    bit issued;
    k = {key_u, key_d, key_l, key_r};
    e = k & ~m_kq;
    e_mv = 4'b0000;
    issued = 1'b0;
    if (restart) begin
      m_ph = 0; m_cnt = 0; m_pv = 1'b0; m_ract = 1'b0;
    end else if (m_ph == 0) begin
      if (e != 4'b0000) begin m_ph = 1; m_last = -1000; end
    end else if (m_ph == 1) begin
      if (frog_hit) begin
        m_ph = 2; m_pv = 1'b0; m_ract = 1'b0;
      end else if (frog_home) begin
        m_ph = 3; m_pv = 1'b0; m_ract = 1'b0;
      end else begin
        rq = -1;
        if (e[3] && !e[2])      rq = 3;
        else if (e[2] && !e[3]) rq = 2;
        else if (e[1] && !e[0]) rq = 1;
        else if (e[0] && !e[1]) rq = 0;
`ifdef FROG_AUTO_REPEAT_EN
        if (rq < 0 && e == 4'b0000 && m_ract && k[m_rdir] && (m_cyc - m_last) >= RP) rq = m_rdir;
`endif
        if ((m_cyc - m_last) < CD) begin
          if (rq >= 0) begin m_pv = 1'b1; m_pd = rq; end
        end else if (rq >= 0 || m_pv) begin
          d = (rq >= 0) ? rq : m_pd;
          e_mv[d] = 1'b1;
          m_cnt++;
          m_last = m_cyc; m_pv = 1'b0; m_ract = 1'b1; m_rdir = d; issued = 1'b1;
        end
        if (!issued && !k[m_rdir]) m_ract = 1'b0;
      end
    end
    m_kq = k;
    m_cyc++;
  endtask

  task automatic step();
    logic [3:0] mv;
    int c8, c2;
    @(posedge clk);
    model_clock();
    #1;
    mv = {bus.move_u, bus.move_d, bus.move_l, bus.move_r};
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    checks++;
    assert (mv === e_mv) else begin
      errors++; $error("FAIL moves cyc=%0d observed %b expected %b", m_cyc, mv, e_mv);
    end
    checks++;
    assert (bus.game_state === 2'(m_ph)) else begin
      errors++; $error("FAIL game_state cyc=%0d observed %b expected %b", m_cyc, bus.game_state, 2'(m_ph));
    end
    checks++;
    assert (bus.move_count === 8'(c8)) else begin
      errors++; $error("FAIL move_count cyc=%0d observed %0d expected %0d", m_cyc, bus.move_count, c8);
    end
    checks++;
    assert (bus2.move_count === 2'(c2)) else begin
      errors++; $error("FAIL move_count_w2 cyc=%0d observed %0d expected %0d", m_cyc, bus2.move_count, c2);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
    key_u = u; key_d = d; key_l = l; key_r = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({bus.move_u, bus.move_d, bus.move_l, bus.move_r} === 4'b0000) else begin
      errors++; $error("FAIL %s_moves observed %b expected 0000", tag, {bus.move_u, bus.move_d, bus.move_l, bus.move_r});
    end
    checks++;
    assert (bus.game_state === 2'b00) else begin
      errors++; $error("FAIL %s_state observed %b expected 00", tag, bus.game_state);
    end
    checks++;
    assert (bus.move_count === 8'd0 && bus2.move_count === 2'd0) else begin
      errors++; $error("FAIL %s_count observed %0d/%0d expected 0/0", tag, bus.move_count, bus2.move_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0; restart = 1'b0; frog_hit = 1'b0; frog_home = 1'b0;
    set_keys(1'b1, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    key_u = 1'b0;
    #1 reset = 1'b1;
    idle(2);

    // Enter play on key_u, then first real move on key_l
    key_u = 1'b1; step();
    idle(2);
    key_u = 1'b0; key_l = 1'b1; step();
    key_l = 1'b0; idle(6);

    // Cooldown with pending overwrite: r issues, u then d queue, d issues at release
    key_r = 1'b1; step();
    key_u = 1'b1; step();
    key_d = 1'b1; step();
    idle(8);
    set_keys(1'b0, 1'b0, 1'b0, 1'b0); idle(6);

    // Same-cycle arbitration cases
    set_keys(1'b0, 1'b0, 1'b1, 1'b1); step();
    set_keys(1'b0, 1'b0, 1'b0, 1'b0); idle(6);
    set_keys(1'b1, 1'b0, 1'b1, 1'b0); step();
    set_keys(1'b0, 1'b0, 1'b0, 1'b0); idle(6);
    set_keys(1'b0, 1'b1, 1'b1, 1'b0); step();
    set_keys(1'b0, 1'b0, 1'b0, 1'b0); idle(6);

    // Hit and home together at the release edge while a move is pending
    key_l = 1'b1; step();
    key_l = 1'b0; step();
    key_r = 1'b1; step();
    step();
    frog_hit = 1'b1; frog_home = 1'b1; step();
    frog_hit = 1'b0; frog_home = 1'b0; key_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_keys(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    restart = 1'b1; step();
    restart = 1'b0; idle(2);

    // Hold a key for 30 cycles
    key_u = 1'b1; step();
    key_u = 1'b0; idle(3);
    key_l = 1'b1; idle(30);
    key_l = 1'b0; idle(5);

    // Reach WON, then restart
    frog_home = 1'b1; step();
    frog_home = 1'b0; key_d = 1'b1; idle(3);
    key_d = 1'b0; restart = 1'b1; step();
    restart = 1'b0; idle(2);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) key_u = ~key_u;
      if ($urandom_range(0, 3) == 0) key_d = ~key_d;
      if ($urandom_range(0, 3) == 0) key_l = ~key_l;
      if ($urandom_range(0, 3) == 0) key_r = ~key_r;
      frog_hit  = ($urandom_range(0, 99) == 0);
      frog_home = ($urandom_range(0, 99) == 0);
      restart   = ($urandom_range(0, 39) == 0);
      step();
    end
    frog_hit = 1'b0; frog_home = 1'b0;
    restart = 1'b1; step();
    restart = 1'b0;

    // Asynchronous reset while a move pulse is high
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      set_keys(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      if (e_mv != 4'b0000) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++; $error("FAIL pulse_search observed none expected a pulse within 300 cycles");
    end
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1 reset = 1'b1;
    idle(3);
    key_r = 1'b1; step();
    key_r = 1'b0; step();
    key_l = 1'b1; idle(3);
    key_l = 1'b0; idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
